piece_overlay_ctrl: RTL and testbench
=====================================

Name: piece_overlay_ctrl

Overview:
- Holds the active-piece layer of the playfield: a ROWS x COLS bitmap, separate from the settled stack.
- Spawns a new piece into the top two rows and applies rotate, left/right shift and gravity drop, each gated by wall and stack collision checks.
- Signals lock when the piece can no longer fall.
- Sits between the input/rotation logic and the board-merge and render blocks.

Parameters:
- ROWS, 22, playfield height in rows; row ROWS-1 is the top row.
- COLS, 10, playfield width in columns; column 0 is the leftmost column.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous, active-low reset.
- spawn  input  1  request to load new_block.
- new_block  input  2xCOLS  new_block[0] loads into row ROWS-1; new_block[1] loads into row ROWS-2.
- rot_req  input  1  rotate request.
- can_rotate  input  1  next_rotation is legal; supplied by the rotation checker.
- next_rotation  input  ROWSxCOLS  rotated candidate layer.
- move_left  input  1  shift request toward column 0.
- move_right  input  1  shift request toward column COLS-1.
- drop_tick  input  1  gravity or soft-drop step.
- board  input  ROWSxCOLS  settled stack.
- active  output  ROWSxCOLS  current piece layer.
- piece_valid  output  1  high in state ACTIVE.
- lock_pulse  output  1  one-cycle lock strobe.
- game_over  output  1  sticky spawn-collision flag.

Behaviour:
- Reset (async, Reset_n=0): active all zero, state EMPTY, piece_valid=0, lock_pulse=0, game_over=0. Reset mid-operation discards the piece immediately.
- All outputs are registered. Every accepted operation appears on active one cycle after the request cycle.
- States: EMPTY, ACTIVE, LOCK, OVER.
- EMPTY:
  - spawn=1 loads new_block into rows ROWS-1 and ROWS-2 and zeroes all other rows.
  - If the loaded rows overlap board rows ROWS-1/ROWS-2: go to OVER and set game_over.
  - Otherwise go to ACTIVE.
  - All other inputs are ignored in EMPTY.
- ACTIVE: at most one operation per cycle, in priority order:
  1. spawn: ignored.
  2. rot_req && can_rotate: active <= next_rotation. No collision check here; can_rotate is trusted.
  3. move_left XOR move_right: shift every row by one column.
     - Blocked (active unchanged) if any set bit is in the wall-side column (column 0 for left, column COLS-1 for right), or if the shifted layer ANDed with board is non-zero.
     - Both move inputs high together: no move.
  4. drop_tick: row r <= row r+1 and the top row becomes zero.
     - Blocked if any bit is set in row 0, or if the shifted layer ANDed with board is non-zero.
     - When blocked: go to LOCK with active held unchanged.
  - A rejected rotate falls through to the next priority item in the same cycle.
  - A blocked shift does not fall through to drop.
- LOCK: lasts exactly one cycle.
  - lock_pulse=1, active still holds the piece so the merge block can OR it into the stack.
  - Next cycle: active cleared, go to EMPTY.
  - All inputs are ignored in LOCK.
- OVER: active holds the colliding spawn, game_over=1. Only reset exits OVER.
- piece_valid=1 only in ACTIVE. lock_pulse=1 only in LOCK.
- All collision checks are pure bitwise AND/OR over ROWSxCOLS; there is no arithmetic.

Optional Feature:
- Macro: PIECE_HARD_DROP_EN.
- When defined:
  - Adds input hard_drop (1 bit), priority just below rotate.
  - Once accepted, sets an internal falling flag; the piece then drops one row per cycle, ignoring rotate/move/drop_tick, until blocked, then goes to LOCK as normal.
  - The flag is cleared by LOCK or reset.
- When undefined: no hard_drop port, no falling flag; behaviour exactly as described above.

Test Plan:
- Reset then spawn with new_block={10'h078,10'h030}, board empty -> next cycle row21=0x078, row20=0x030, other rows 0, piece_valid=1.
- Piece in column 0, move_left=1 -> active unchanged. Then move_right=1 -> every row shifted toward column COLS-1 by one next cycle.
- drop_tick x20 on empty board with two-row piece -> piece reaches rows 1/0. 21st tick -> lock_pulse high one cycle with active intact, then active=0 and state EMPTY.
- board row19 = 10'h3FF, piece at rows 21/20, drop_tick -> lock_pulse asserts, no row change.
- rot_req=1, can_rotate=1, and move_left=1 in the same cycle -> active = next_rotation, no shift. Same with can_rotate=0 -> the shift is applied.
- board row21 overlaps new_block, spawn -> game_over=1 sticky; further inputs ignored. Reset_n pulsed mid-drop -> all outputs 0 immediately.

Source files
------------

// File: rtl/piece_overlay_ctrl.sv
// ----------------------------------------------------------------------------
// piece_overlay_ctrl
//
// Purpose:
//   Holds the active-piece layer of the playfield. This is a ROWS x COLS bitmap
//   that is kept separate from the settled stack. The block does four things:
//     - spawns a new piece into the top two rows;
//     - applies rotate, left/right shift and gravity drop, each checked for
//       collision against the walls and the stack;
//     - raises a one-cycle lock strobe when the piece can no longer fall;
//     - raises a sticky game-over flag when a spawn collides with the stack.
//
// Layer packing (applies to active, board and next_rotation):
//   Row r occupies bits [r*COLS +: COLS]. Bit c within a row is column c.
//   Row ROWS-1 is the top row and column 0 is the leftmost column.
//   new_block packs two rows: upper COLS bits -> row ROWS-1 (new_block[0]),
//   lower COLS bits -> row ROWS-2 (new_block[1]).
//
// Ports:
//   Clk            in   system clock
//   Reset_n        in   asynchronous active-low reset
//   spawn          in   load new_block (honoured in EMPTY only)
//   new_block      in   2*COLS  two spawn rows
//   rot_req        in   rotate request
//   can_rotate     in   next_rotation is legal (trusted, not re-checked)
//   next_rotation  in   ROWS*COLS rotated candidate layer
//   move_left      in   shift toward column 0
//   move_right     in   shift toward column COLS-1
//   drop_tick      in   gravity / soft-drop step
//   board          in   ROWS*COLS settled stack
//   hard_drop      in   (PIECE_HARD_DROP_EN only) start a free fall
//   active         out  ROWS*COLS current piece layer
//   piece_valid    out  high while a piece is ACTIVE
//   lock_pulse     out  one-cycle lock strobe
//   game_over      out  sticky spawn-collision flag
//
// Optional feature:
//   Define PIECE_HARD_DROP_EN to add the hard_drop input and the falling
//   flag. While the flag is set, the piece drops one row per cycle until it
//   is blocked, and then it locks.
// ----------------------------------------------------------------------------
module piece_overlay_ctrl #(
    parameter int ROWS = 22,
    parameter int COLS = 10
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   spawn,
    input  logic [2*COLS-1:0]      new_block,
    input  logic                   rot_req,
    input  logic                   can_rotate,
    input  logic [ROWS*COLS-1:0]   next_rotation,
    input  logic                   move_left,
    input  logic                   move_right,
    input  logic                   drop_tick,
    input  logic [ROWS*COLS-1:0]   board,
`ifdef PIECE_HARD_DROP_EN
    input  logic                   hard_drop,
`endif
    output logic [ROWS*COLS-1:0]   active,
    output logic                   piece_valid,
    output logic                   lock_pulse,
    output logic                   game_over
);

    localparam int N = ROWS * COLS;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACTIVE = 2'd1,
        S_LOCK   = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    // Mask with one bit set in column c of every row.
    function automatic logic [N-1:0] col_mask(input int c);
        logic [N-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            m[r*COLS + c] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [N-1:0] LEFT_COL  = col_mask(0);
    localparam logic [N-1:0] RIGHT_COL = col_mask(COLS - 1);
    localparam logic [N-1:0] ROW0      = {{(N-COLS){1'b0}}, {COLS{1'b1}}};

    state_t          state_q, state_d;
    logic [N-1:0]    active_q, active_d;
    logic            piece_valid_q, piece_valid_d;
    logic            lock_pulse_q, lock_pulse_d;
    logic            game_over_q, game_over_d;
`ifdef PIECE_HARD_DROP_EN
    logic            falling_q, falling_d;
`endif

    // Candidate layers and their legality, all pure bitwise logic.
    logic [N-1:0]    spawn_layer;
    logic            spawn_hit;
    logic [N-1:0]    left_layer, right_layer, drop_layer, shift_layer;
    logic            left_ok, right_ok, drop_ok, shift_ok;

    always_comb begin
        spawn_layer = {new_block, {(N-2*COLS){1'b0}}};
        spawn_hit   = |(spawn_layer & board);

        // The wall masks stop bits from wrapping into the neighbouring row.
        // A move that would wrap is also rejected by the wall check.
        left_layer  = (active_q >> 1) & ~RIGHT_COL;
        right_layer = (active_q << 1) & ~LEFT_COL;
        drop_layer  = active_q >> COLS;

        left_ok  = ~|(active_q & LEFT_COL)  && ~|(left_layer & board);
        right_ok = ~|(active_q & RIGHT_COL) && ~|(right_layer & board);
        drop_ok  = ~|(active_q & ROW0)      && ~|(drop_layer & board);

        shift_layer = move_left ? left_layer : right_layer;
        shift_ok    = move_left ? left_ok    : right_ok;
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_EMPTY;
            active_q      <= '0;
            piece_valid_q <= 1'b0;
            lock_pulse_q  <= 1'b0;
            game_over_q   <= 1'b0;
`ifdef PIECE_HARD_DROP_EN
            falling_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            piece_valid_q <= piece_valid_d;
            lock_pulse_q  <= lock_pulse_d;
            game_over_q   <= game_over_d;
`ifdef PIECE_HARD_DROP_EN
            falling_q     <= falling_d;
`endif
        end
    end

    // Next-state logic. At most one operation is taken per cycle,
    // in priority order.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
`ifdef PIECE_HARD_DROP_EN
        falling_d = falling_q;
`endif
        case (state_q)
            S_EMPTY: begin
                if (spawn) begin
                    active_d = spawn_layer;
                    state_d  = spawn_hit ? S_OVER : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
`ifdef PIECE_HARD_DROP_EN
                if (falling_q) begin
                    if (drop_ok) active_d = drop_layer;
                    else         state_d  = S_LOCK;
                end else
`endif
                if (rot_req && can_rotate) begin
                    active_d = next_rotation;
                end
`ifdef PIECE_HARD_DROP_EN
                else if (hard_drop) begin
                    falling_d = 1'b1;
                    if (drop_ok) active_d = drop_layer;
                    else         state_d  = S_LOCK;
                end
`endif
                // A blocked shift still consumes the cycle,
                // so it never falls through to the drop.
                else if (move_left ^ move_right) begin
                    if (shift_ok) active_d = shift_layer;
                end else if (drop_tick) begin
                    if (drop_ok) active_d = drop_layer;
                    else         state_d  = S_LOCK;
                end
            end
            S_LOCK: begin
                active_d = '0;
                state_d  = S_EMPTY;
`ifdef PIECE_HARD_DROP_EN
                falling_d = 1'b0;
`endif
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d  = S_EMPTY;
                active_d = '0;
            end
        endcase
    end

    // Output logic. Decoding from the next state lets the flags be
    // registered and still line up with the state they describe.
    always_comb begin
        piece_valid_d = (state_d == S_ACTIVE);
        lock_pulse_d  = (state_d == S_LOCK);
        game_over_d   = (state_d == S_OVER);
    end

    assign active      = active_q;
    assign piece_valid = piece_valid_q;
    assign lock_pulse  = lock_pulse_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_piece_overlay_ctrl.sv
module tb_piece_overlay_ctrl;

    localparam int ROWS = 22;
    localparam int COLS = 10;
    localparam int N    = ROWS * COLS;

    logic                Clk;
    logic                Reset_n;
    logic                spawn;
    logic [2*COLS-1:0]   new_block;
    logic                rot_req;
    logic                can_rotate;
    logic [N-1:0]        next_rotation;
    logic                move_left;
    logic                move_right;
    logic                drop_tick;
    logic [N-1:0]        board;
`ifdef PIECE_HARD_DROP_EN
    logic                hard_drop;
`endif
    logic [N-1:0]        active;
    logic                piece_valid;
    logic                lock_pulse;
    logic                game_over;

    piece_overlay_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .spawn         (spawn),
        .new_block     (new_block),
        .rot_req       (rot_req),
        .can_rotate    (can_rotate),
        .next_rotation (next_rotation),
        .move_left     (move_left),
        .move_right    (move_right),
        .drop_tick     (drop_tick),
        .board         (board),
`ifdef PIECE_HARD_DROP_EN
        .hard_drop     (hard_drop),
`endif
        .active        (active),
        .piece_valid   (piece_valid),
        .lock_pulse    (lock_pulse),
        .game_over     (game_over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    // The piece is held as a grid of cells. mode: 0 empty, 1 falling piece,
    // 2 locking, 3 game over.
    logic [COLS-1:0] m_row [ROWS];
    int              m_mode;
    logic            m_go;

    function automatic logic board_cell(input int r, input int c);
        return board[r*COLS + c];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) m_row[r] = '0;
        m_mode = 0;
        m_go   = 1'b0;
    endtask

    // dir: -1 toward column 0, +1 toward column COLS-1.
    task automatic model_shift(input int dir);
        logic [COLS-1:0] cand [ROWS];
        logic ok;
        ok = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            cand[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                if (m_row[r][c]) begin
                    if (c + dir < 0 || c + dir >= COLS) ok = 1'b0;
                    else begin
                        cand[r][c + dir] = 1'b1;
                        if (board_cell(r, c + dir)) ok = 1'b0;
                    end
                end
            end
        end
        if (ok) for (int r = 0; r < ROWS; r++) m_row[r] = cand[r];
    endtask

    task automatic model_drop();
        logic [COLS-1:0] cand [ROWS];
        logic ok;
        ok = (m_row[0] == '0);
        for (int r = 0; r < ROWS; r++) begin
            cand[r] = (r == ROWS - 1) ? '0 : m_row[r + 1];
            for (int c = 0; c < COLS; c++)
                if (cand[r][c] && board_cell(r, c)) ok = 1'b0;
        end
        if (ok) for (int r = 0; r < ROWS; r++) m_row[r] = cand[r];
        else    m_mode = 2;
    endtask

    task automatic model_next();
        logic hit;
        case (m_mode)
            0: if (spawn) begin
                for (int r = 0; r < ROWS; r++) m_row[r] = '0;
                m_row[ROWS-1] = new_block[2*COLS-1:COLS];
                m_row[ROWS-2] = new_block[COLS-1:0];
                hit = 1'b0;
                for (int c = 0; c < COLS; c++)
                    if ((m_row[ROWS-1][c] && board_cell(ROWS-1, c)) ||
                        (m_row[ROWS-2][c] && board_cell(ROWS-2, c))) hit = 1'b1;
                if (hit) begin m_mode = 3; m_go = 1'b1; end
                else m_mode = 1;
            end
            1: begin
                if (rot_req && can_rotate) begin
                    for (int r = 0; r < ROWS; r++) m_row[r] = next_rotation[r*COLS +: COLS];
                end else if (move_left && !move_right) model_shift(-1);
                else if (move_right && !move_left) model_shift(1);
                else if (drop_tick) model_drop();
            end
            2: begin
                for (int r = 0; r < ROWS; r++) m_row[r] = '0;
                m_mode = 0;
            end
            default: ;
        endcase
    endtask

    function automatic logic [N-1:0] model_layer();
        logic [N-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*COLS +: COLS] = m_row[r];
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".active"},      active,      model_layer());
        chk({tag, ".piece_valid"}, piece_valid, (m_mode == 1));
        chk({tag, ".lock_pulse"},  lock_pulse,  (m_mode == 2));
        chk({tag, ".game_over"},   game_over,   m_go);
    endtask

    task automatic step();
        if (!Reset_n) model_reset();
        else          model_next();
        @(posedge Clk);
        #1;
        check_outputs("cyc");
    endtask

    function automatic logic [COLS-1:0] row_of(input logic [N-1:0] v, input int r);
        return v[r*COLS +: COLS];
    endfunction

    task automatic pulse_reset(input string tag);
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        step();
        Reset_n = 1'b1;
    endtask

    function automatic logic [N-1:0] sparse_rand();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 7) == 0);
        return v;
    endfunction

    logic [N-1:0] nr;

    initial begin
        Reset_n = 1'b0;
        spawn = 0; new_block = '0; rot_req = 0; can_rotate = 0;
        next_rotation = '0; move_left = 0; move_right = 0; drop_tick = 0;
        board = '0;
`ifdef PIECE_HARD_DROP_EN
        hard_drop = 0;
`endif
        #1;
        model_reset();
        check_outputs("reset");
        step(); step();
        Reset_n = 1'b1;
        step();

        // Spawn a piece onto an empty board.
        new_block = {10'h078, 10'h030};
        spawn = 1; step(); spawn = 0;
        chk("spawn_r21", row_of(active, 21), 10'h078);
        chk("spawn_r20", row_of(active, 20), 10'h030);
        chk("spawn_r19", row_of(active, 19), 10'h000);
        chk("spawn_vld", piece_valid, 1'b1);
        chk("model_r21", m_row[21], 10'h078);

        // Shift left until the piece touches the wall, then press once more.
        move_left = 1; repeat (3) step();
        chk("left3_r21", row_of(active, 21), 10'h00F);
        step();
        chk("wall_r21", row_of(active, 21), 10'h00F);
        move_left = 0; move_right = 1; step(); move_right = 0;
        chk("right_r21", row_of(active, 21), 10'h01E);
        chk("right_r20", row_of(active, 20), 10'h00C);

        // Gravity down to the floor, then lock.
        drop_tick = 1; repeat (20) step();
        chk("floor_r1", row_of(active, 1), 10'h01E);
        chk("floor_r0", row_of(active, 0), 10'h00C);
        step();
        chk("lock_pulse", lock_pulse, 1'b1);
        chk("lock_r0", row_of(active, 0), 10'h00C);
        drop_tick = 0; step();
        chk("post_lock_active", active, '0);
        chk("post_lock_vld", piece_valid, 1'b0);

        // Stack directly below the spawn rows: the first drop locks the piece.
        board[19*COLS +: COLS] = 10'h3FF;
        spawn = 1; step(); spawn = 0;
        drop_tick = 1; step(); drop_tick = 0;
        chk("stack_lock", lock_pulse, 1'b1);
        chk("stack_r21", row_of(active, 21), 10'h078);
        step();
        board = '0;

        // Rotation takes priority over a shift; a rejected rotation falls
        // through to the shift.
        spawn = 1; step(); spawn = 0;
        nr = '0;
        nr[21*COLS +: COLS] = 10'h010;
        nr[20*COLS +: COLS] = 10'h038;
        next_rotation = nr;
        rot_req = 1; can_rotate = 1; move_left = 1; step();
        chk("rot_taken", active, nr);
        can_rotate = 0; step();
        chk("rot_rej_r21", row_of(active, 21), 10'h008);
        chk("rot_rej_r20", row_of(active, 20), 10'h01C);
        rot_req = 0; move_left = 0;

        // Reset in the middle of a drop.
        drop_tick = 1; step(); step();
        pulse_reset("mid_reset");
        chk("mid_reset_active", active, '0);
        drop_tick = 0;

        // Spawn onto an occupied top row: game over, and it stays set.
        board[21*COLS +: COLS] = 10'h0F0;
        new_block = {10'h078, 10'h030};
        spawn = 1; step(); spawn = 0;
        chk("over_flag", game_over, 1'b1);
        chk("over_vld", piece_valid, 1'b0);
        chk("over_r21", row_of(active, 21), 10'h078);
        for (int i = 0; i < 10; i++) begin
            spawn = $urandom_range(0, 1); drop_tick = $urandom_range(0, 1);
            move_left = $urandom_range(0, 1); board = '0;
            step();
        end
        chk("over_sticky", game_over, 1'b1);
        spawn = 0; drop_tick = 0; move_left = 0;
        pulse_reset("over_reset");

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) begin
                board = '0;
                for (int b = 0; b < 8 * COLS; b++) board[b] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0)
                    board[(ROWS-1)*COLS + $urandom_range(0, COLS-1)] = 1'b1;
            end
            spawn         = ($urandom_range(0, 1) == 0);
            new_block     = $urandom_range(0, (1 << (2*COLS)) - 1);
            rot_req       = ($urandom_range(0, 3) == 0);
            can_rotate    = $urandom_range(0, 1);
            next_rotation = sparse_rand();
            move_left     = ($urandom_range(0, 2) == 0);
            move_right    = ($urandom_range(0, 2) == 0);
            drop_tick     = ($urandom_range(0, 1) == 0);
`ifdef PIECE_HARD_DROP_EN
            hard_drop     = 1'b0;
`endif
            if (i % 500 == 499) pulse_reset("rand_reset");
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
